// File: rtl/divider_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the pipelined restoring divider: partial-remainder width
// helper and the parameterised inter-stage bus typedef.
package divider_pkg;

   function automatic int datapath_len(input int dividendlen, input int divisorlen);
      return dividendlen + divisorlen - 1;
   endfunction

endpackage

// Stage bus {din, divisor, qin}; widths come from the instantiating module's parameters.
`define DIVIDER_STAGE_T(name, dpw, dvw, qw) \
   typedef struct packed {                  \
      logic [(dpw)-1:0] din;                \
      logic [(dvw)-1:0] divisor;            \
      logic [(qw)-1:0]  qin;                \
   } name

// File: rtl/divider_slice_core.sv
`timescale 1ns/1ps
// Combinational compare/subtract for one divider stage: resolves quotient bit SHIFT
// and produces the next partial remainder.
module divider_slice_core
   import divider_pkg::*;
#(
   parameter int  SHIFT       = 3,
   parameter int  DIVIDENDLEN = 4,
   parameter int  DIVISORLEN  = 2,
   localparam int DATAPATHLEN = datapath_len(DIVIDENDLEN, DIVISORLEN)
) (
   input  logic [DATAPATHLEN-1:0] din,
   input  logic [DIVISORLEN-1:0]  divisor,
   input  logic [DIVIDENDLEN-1:0] qin,
   output logic [DATAPATHLEN-1:0] next_dout,
   output logic [DIVIDENDLEN-1:0] next_q,
   output logic [DIVISORLEN-1:0]  next_div
);

   logic [DATAPATHLEN-1:0] sd;
   logic                   ge;

   // SHIFT + DIVISORLEN <= DATAPATHLEN, so the shifted divisor never loses bits.
   assign sd = DATAPATHLEN'(divisor) << SHIFT;
   assign ge = (din >= sd);

   assign next_dout = ge ? (din - sd) : din;
   assign next_div  = divisor;

   // NOTE: next_q takes a full default before the single-bit override, so no latch is inferred.
   always_comb begin
      next_q        = qin;
      next_q[SHIFT] = ge;
   end

endmodule

// File: rtl/divider_slice.sv
`timescale 1ns/1ps
// divider_slice: one registered stage of a pipelined restoring divider (latency 1).
// Define DIVIDER_SLICE_DIVZERO_EN to add the dz_in/dz_out divide-by-zero flag chain.
module divider_slice
   import divider_pkg::*;
#(
   parameter int  SHIFT       = 3,
   parameter int  DIVIDENDLEN = 4,
   parameter int  DIVISORLEN  = 2,
   localparam int DATAPATHLEN = datapath_len(DIVIDENDLEN, DIVISORLEN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   input  logic [DATAPATHLEN-1:0] din,
   input  logic [DIVISORLEN-1:0]  divisor,
   input  logic [DIVIDENDLEN-1:0] qin,
   output logic                   out_valid,
   output logic [DIVIDENDLEN-1:0] quotient,
   output logic [DATAPATHLEN-1:0] dout,
   output logic [DIVISORLEN-1:0]  divout
`ifdef DIVIDER_SLICE_DIVZERO_EN
   ,
   input  logic                   dz_in,
   output logic                   dz_out
`endif
);

   `DIVIDER_STAGE_T(stage_t, DATAPATHLEN, DIVISORLEN, DIVIDENDLEN);

   stage_t nxt;
   stage_t cur;
   logic   valid_q;

   divider_slice_core #(
      .SHIFT       (SHIFT),
      .DIVIDENDLEN (DIVIDENDLEN),
      .DIVISORLEN  (DIVISORLEN)
   ) u_core (
      .din       (din),
      .divisor   (divisor),
      .qin       (qin),
      .next_dout (nxt.din),
      .next_q    (nxt.qin),
      .next_div  (nxt.divisor)
   );

   // Data loads every cycle regardless of in_valid; consumers qualify with out_valid.
   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         cur     <= '0;
      end else begin
         valid_q <= in_valid;
         cur     <= nxt;
      end
   end

`ifdef DIVIDER_SLICE_DIVZERO_EN
   logic dz_q;

   always_ff @(posedge clk) begin
      if (!rst_n) dz_q <= 1'b0;
      else        dz_q <= dz_in | (divisor == '0);
   end

   assign dz_out = dz_q;
`endif

   assign out_valid = valid_q;
   assign quotient  = cur.qin;
   assign dout      = cur.din;
   assign divout    = cur.divisor;

endmodule

// File: tb/tb_divider_slice.sv
`timescale 1ns/1ps
// Self-checking bench for divider_slice: directed, sweep, random and reset checks on one
// stage, plus a four-stage chain checked against integer division.
module tb_divider_slice;

   localparam int DL = 4;
   localparam int VL = 2;
   localparam int PL = 5;
   localparam int SH = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          in_valid;
   logic [PL-1:0] din;
   logic [VL-1:0] divisor;
   logic [DL-1:0] qin;
   logic          out_valid;
   logic [DL-1:0] quotient;
   logic [PL-1:0] dout;
   logic [VL-1:0] divout;
`ifdef DIVIDER_SLICE_DIVZERO_EN
   logic          dz_in;
   logic          dz_out;
`endif

   divider_slice #(.SHIFT(SH), .DIVIDENDLEN(DL), .DIVISORLEN(VL)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din       (din),
      .divisor   (divisor),
      .qin       (qin),
      .out_valid (out_valid),
      .quotient  (quotient),
      .dout      (dout),
      .divout    (divout)
`ifdef DIVIDER_SLICE_DIVZERO_EN
      ,
      .dz_in     (dz_in),
      .dz_out    (dz_out)
`endif
   );

   // Four-stage chain, SHIFT 3 down to 0; index k feeds stage k, index 4 is the result.
   logic          c_valid [0:4];
   logic [PL-1:0] c_din   [0:4];
   logic [VL-1:0] c_div   [0:4];
   logic [DL-1:0] c_q     [0:4];
`ifdef DIVIDER_SLICE_DIVZERO_EN
   logic          c_dz    [0:4];
`endif

   for (genvar k = 0; k < 4; k++) begin : g_chain
      divider_slice #(.SHIFT(3 - k), .DIVIDENDLEN(DL), .DIVISORLEN(VL)) u_stage (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (c_valid[k]),
         .din       (c_din[k]),
         .divisor   (c_div[k]),
         .qin       (c_q[k]),
         .out_valid (c_valid[k+1]),
         .quotient  (c_q[k+1]),
         .dout      (c_din[k+1]),
         .divout    (c_div[k+1])
`ifdef DIVIDER_SLICE_DIVZERO_EN
         ,
         .dz_in     (c_dz[k]),
         .dz_out    (c_dz[k+1])
`endif
      );
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: quotient bit SH is set iff the remainder covers divisor * 2^SH.
   task automatic ref_stage(input int d, input int v, input int q, output int eq, output int ed);
      int weight;
      weight = 1 << SH;
      if (d >= v * weight) begin
         ed = d - v * weight;
         eq = q | weight;
      end else begin
         ed = d;
         eq = q & ~weight;
      end
   endtask

   task automatic drive_check(input string tag, input logic v, input logic [PL-1:0] d,
                              input logic [VL-1:0] dv, input logic [DL-1:0] q, input logic dzi);
      int eq, ed;
      in_valid = v;
      din      = d;
      divisor  = dv;
      qin      = q;
`ifdef DIVIDER_SLICE_DIVZERO_EN
      dz_in    = dzi;
`endif
      tick();
      ref_stage(int'(d), int'(dv), int'(q), eq, ed);
      check({tag, "_valid"}, 32'(out_valid), 32'(v));
      check({tag, "_q"},     32'(quotient), 32'(eq));
      check({tag, "_dout"},  32'(dout), 32'(ed));
      check({tag, "_div"},   32'(divout), 32'(dv));
      check({tag, "_qlow"},  32'((quotient ^ q) & 4'b0111), 32'd0);
`ifdef DIVIDER_SLICE_DIVZERO_EN
      check({tag, "_dz"},    32'(dz_out), 32'(dzi | (dv == 0)));
`endif
   endtask

   int unsigned exp_q[$];

   task automatic chain_sample();
      int unsigned e;
      if (c_valid[4]) begin
         check("chain_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("chain_quot", 32'(c_q[4]), e >> 8);
            check("chain_rem",  32'(c_din[4]), e & 32'hff);
         end
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      din      = '0;
      divisor  = '0;
      qin      = '0;
`ifdef DIVIDER_SLICE_DIVZERO_EN
      dz_in    = 1'b0;
      c_dz[0]  = 1'b0;
`endif
      c_valid[0] = 1'b0;
      c_din[0]   = '0;
      c_div[0]   = '0;
      c_q[0]     = '0;

      tick();
      tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_q",     32'(quotient), 32'd0);
      check("rst_dout",  32'(dout), 32'd0);
      check("rst_div",   32'(divout), 32'd0);
      rst_n = 1'b1;

      // Directed vectors with hand-derived expectations.
      drive_check("t_below", 1'b1, 5'd14, 2'd2, 4'b1010, 1'b0);
      check("t_below_qc", 32'(quotient), 32'b0010);
      check("t_below_dc", 32'(dout), 32'd14);
      drive_check("t_equal", 1'b1, 5'd16, 2'd2, 4'b1010, 1'b0);
      check("t_equal_qc", 32'(quotient), 32'b1010);
      check("t_equal_dc", 32'(dout), 32'd0);
      drive_check("t_max", 1'b1, 5'd31, 2'd3, 4'b0010, 1'b0);
      check("t_max_qc", 32'(quotient), 32'b1010);
      check("t_max_dc", 32'(dout), 32'd7);
      drive_check("t_dz", 1'b1, 5'd9, 2'd0, 4'b1010, 1'b0);
      check("t_dz_qc", 32'(quotient), 32'b1010);
      check("t_dz_dc", 32'(dout), 32'd9);
`ifdef DIVIDER_SLICE_DIVZERO_EN
      check("t_dz_flag", 32'(dz_out), 32'd1);
`endif

      for (int i = 0; i < 128; i++)
         drive_check("sweep", 1'b1, 5'(i), 2'(i >> 5), 4'b1010, 1'b0);

      for (int i = 0; i < 200; i++)
         drive_check("rand", 1'($urandom), 5'($urandom), 2'($urandom), 4'($urandom),
                     1'($urandom_range(0, 3) == 0));

      // Reset in mid-stream drops the in-flight operation.
      in_valid = 1'b1;
      din      = 5'd31;
      divisor  = 2'd3;
      qin      = 4'b1111;
      rst_n    = 1'b0;
      tick();
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_q",     32'(quotient), 32'd0);
      check("mrst_dout",  32'(dout), 32'd0);
      check("mrst_div",   32'(divout), 32'd0);
`ifdef DIVIDER_SLICE_DIVZERO_EN
      check("mrst_dz",    32'(dz_out), 32'd0);
`endif
      rst_n    = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("post_rst_idle", 32'(out_valid), 32'd0);
      end
      in_valid = 1'b1;
      tick();
      check("post_rst_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;

      // Chain: 13 / 3 appears four clocks after it is presented.
      c_valid[0] = 1'b1;
      c_din[0]   = 5'd13;
      c_div[0]   = 2'd3;
      tick();
      c_valid[0] = 1'b0;
      for (int i = 0; i < 2; i++) tick();
      check("chain13_early", 32'(c_valid[4]), 32'd0);
      tick();
      check("chain13_valid", 32'(c_valid[4]), 32'd1);
      check("chain13_quot",  32'(c_q[4]), 32'd4);
      check("chain13_rem",   32'(c_din[4]), 32'd1);
      tick();

      // Back-to-back random stream through the chain against integer / and %.
      for (int i = 0; i < 120; i++) begin
         int unsigned a, b;
         a = $urandom_range(0, 15);
         b = $urandom_range(1, 3);
         c_valid[0] = 1'($urandom_range(0, 3) != 0);
         c_din[0]   = 5'(a);
         c_div[0]   = 2'(b);
         if (c_valid[0]) exp_q.push_back(((a / b) << 8) | (a % b));
         tick();
         chain_sample();
      end
      c_valid[0] = 1'b0;
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         tick();
         chain_sample();
      end
      check("chain_drain", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/divider_slice.md
Name: divider_slice

Overview:
- One stage of a pipelined restoring long divider; resolves a single quotient bit, selected by the SHIFT parameter.
- The stage compares the partial remainder against the divisor shifted left by SHIFT. If the remainder is large enough, it subtracts and sets quotient bit SHIFT.
- Results are registered, so the stage has one clock of latency.
- DIVIDENDLEN stages are chained with SHIFT = DIVIDENDLEN-1 down to 0 to form a full divider.

Parameters:
- SHIFT, 3, quotient bit position this stage resolves; legal range 0..DIVIDENDLEN-1.
- DIVIDENDLEN, 4, dividend and quotient width.
- DIVISORLEN, 2, divisor width.
- Derived localparam DATAPATHLEN = DIVIDENDLEN+DIVISORLEN-1, the partial-remainder width.
- Parameter order is SHIFT, DIVIDENDLEN, DIVISORLEN.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input operands valid this cycle.
- din  input  DATAPATHLEN  incoming partial remainder; the first stage receives the zero-extended dividend.
- divisor  input  DIVISORLEN  divisor.
- qin  input  DIVIDENDLEN  quotient bits resolved by earlier stages.
- out_valid  output  1  registered in_valid.
- quotient  output  DIVIDENDLEN  qin with bit SHIFT replaced.
- dout  output  DATAPATHLEN  updated partial remainder.
- divout  output  DIVISORLEN  divisor forwarded to the next stage.
- Ports are connected by name.

Behaviour:
- Combinational core:
  - sd = divisor zero-extended to DATAPATHLEN, then shifted left by SHIFT. It never overflows because SHIFT+DIVISORLEN <= DATAPATHLEN.
  - ge = (din >= sd), unsigned comparison.
  - next_dout = ge ? din - sd : din.
  - next_q = qin with bit SHIFT = ge; all other bits are copied from qin unchanged.
  - next_div = divisor.
- Registers, on every rising clk edge:
  - rst_n=0: out_valid, quotient, dout and divout all become 0.
  - Otherwise: out_valid<=in_valid, quotient<=next_q, dout<=next_dout, divout<=next_div.
- Data registers load every cycle regardless of in_valid, for the simplest timing. Consumers qualify data with out_valid.
- Latency is exactly 1 cycle. Throughput is one operation per cycle. There is no backpressure and no stall.
- Boundaries:
  - din == sd: ge=1, dout=0.
  - divisor == 0: sd=0, ge=1, dout=din, quotient bit SHIFT=1. Divide-by-zero is not trapped unless the optional feature is compiled in.
  - Reset asserted mid-stream: the next edge clears everything and the operation in flight is dropped. out_valid stays 0 until in_valid is sampled high after reset deasserts.
- All arithmetic is unsigned and truncated to the declared widths. Outputs are driven only from registers.

Optional Feature:
- Macro: DIVIDER_SLICE_DIVZERO_EN.
- When defined, two ports are added:
  - dz_in  input  1  divide-by-zero flag from the previous stage.
  - dz_out  output  1  registered (dz_in | (divisor == 0)), reset to 0, captured on the same edge as the other outputs.
- When undefined, neither port exists and the stage behaves as above.

Decomposition:
- Package divider_pkg holds:
  - function datapath_len(dividendlen, divisorlen), returning dividendlen+divisorlen-1;
  - packed struct stage_t {din, divisor, qin}, in parameterised form via a parameterised class or typedef macro, used for the inter-stage bus.
- One combinational sub-module, divider_slice_core, computes ge, next_dout, next_q and next_div. divider_slice wraps it with the valid/data registers.

Test Plan:
- Defaults (SHIFT=3, DATAPATHLEN=5), qin=4'b1010, divisor=2, din=14 -> after 1 clk: quotient=4'b0010, dout=14, divout=2, out_valid=1.
- divisor=2, din=16 (equality) -> quotient=4'b1010, dout=0.
- divisor=3, din=31 -> quotient bit3=1, dout=7. Also divisor=0, din=9 -> quotient bit3=1, dout=9, and dz_out=1 when DIVIDER_SLICE_DIVZERO_EN is defined.
- Exhaustive sweep: {divisor,din} over 0..127, one per clk, qin=4'b1010 -> every result matches the reference model one cycle later. Only bit 3 of quotient ever differs from qin.
- Reset: drive valid data, assert rst_n=0 for one edge -> all outputs 0. out_valid stays 0 while in_valid=0 after release.
- Chain of 4 stages (SHIFT 3..0), dividend 13, divisor 3 -> after 4 clks: quotient=4, remainder=1.
